// File: rtl/spi_serf.sv
// spi_serf: SPI mode-3 register slave ("serf") with a 16 x 8 register file.
//   Frame (MSB first): bit15 = R/W (1 = read), bits14:8 = addr, bits7:0 = wdata.
//   Address 0x0F is a read-only WHO_AM_I (0x6A); addr[6:4] != 0 is out of range.
// Ports:
//   clk, rst        system clock, async active-high reset
//   SS_n, SCLK, MOSI  SPI inputs, asynchronous to clk (synchronized internally)
//   MISO            read data, MSB first on frame bits 7..0
//   wr_strb         1-clk pulse on write commit; wr_addr/wr_data hold last commit
//   frm_err         1-clk pulse when SS_n rises before 16 SCLK rises
//   busy            high while a frame is in progress
module spi_serf (
    input  logic       clk,
    input  logic       rst,
    input  logic       SS_n,
    input  logic       SCLK,
    input  logic       MOSI,
    output logic       MISO,
    output logic       wr_strb,
    output logic [6:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frm_err,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, CMD, DATA, HOLD} state_t;
    localparam logic [7:0] WHO_AM_I = 8'h6A;

    // Synchronizers: [0],[1] metastability, [2] previous value for edge detect.
    logic [2:0] ss_q, ss_d, sclk_q, sclk_d, mosi_q, mosi_d;
    // ok_q fills with ones after reset; once ok_q[2] is set the synchronizer
    // holds real samples rather than reset values.
    logic [2:0] ok_q, ok_d;
    // A frame may only start after SS_n has been seen high, so a reset that
    // lands mid-frame does not pick up the tail of that frame.
    logic       armed_q, armed_d;
    state_t     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [15:0] rx_q, rx_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] regs_q [16];
    logic [7:0] regs_d [16];
    logic       miso_q, miso_d, wr_strb_q, wr_strb_d, frm_err_q, frm_err_d, busy_q, busy_d;
    logic [6:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;

    logic        ss_fall, ss_rise, sclk_rise, sclk_fall;
    logic [15:0] rx_shift;
    logic [7:0]  rd_val;

    always_comb begin
        ss_d    = {ss_q[1:0], SS_n};
        sclk_d  = {sclk_q[1:0], SCLK};
        mosi_d  = {mosi_q[1:0], MOSI};
        ok_d    = {ok_q[1:0], 1'b1};
        armed_d = armed_q | (ok_q[2] & ss_q[1]);

        ss_fall   = ss_q[2] & ~ss_q[1];
        ss_rise   = ~ss_q[2] & ss_q[1];
        sclk_rise = ~sclk_q[2] & sclk_q[1];
        sclk_fall = sclk_q[2] & ~sclk_q[1];

        // On the 8th rise rx_shift[7:0] holds {R/W, addr[6:0]}.
        rx_shift = {rx_q[14:0], mosi_q[2]};
        if (rx_shift[6:4] != 3'd0)      rd_val = 8'h00;
        else if (rx_shift[3:0] == 4'hF) rd_val = WHO_AM_I;
        else                            rd_val = regs_q[rx_shift[3:0]];

        state_d   = state_q;
        cnt_d     = cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        regs_d    = regs_q;
        wr_strb_d = 1'b0;
        frm_err_d = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        if (ss_rise && state_q != IDLE) begin
            state_d = IDLE;
            tx_d    = 8'h00;
            if (state_q == HOLD) begin
                if (!rx_q[15] && rx_q[14:12] == 3'd0 && rx_q[11:8] != 4'hF) begin
                    regs_d[rx_q[11:8]] = rx_q[7:0];
                    wr_strb_d = 1'b1;
                    wr_addr_d = rx_q[14:8];
                    wr_data_d = rx_q[7:0];
                end
            end else begin
                frm_err_d = 1'b1;
            end
        end else if (state_q == IDLE) begin
            if (ss_fall && armed_q) begin
                state_d = CMD;
                cnt_d   = 5'd0;
                rx_d    = 16'h0000;
                tx_d    = 8'h00;
            end
        end else begin
            // Rises past the 16th are dropped so the frame stays intact.
            if (sclk_rise && cnt_q < 5'd16) begin
                rx_d  = rx_shift;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd7) begin
                    state_d = DATA;
                    if (rx_shift[7]) tx_d = rd_val;
                end
                if (cnt_q == 5'd15) state_d = HOLD;
            end
            // Shift on falls following rises 9..15 so bit n is set up before its rise.
            if (sclk_fall && cnt_q >= 5'd9 && cnt_q <= 5'd15)
                tx_d = {tx_q[6:0], 1'b0};
        end

        miso_d = (state_d == DATA || state_d == HOLD) && tx_d[7];
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_q      <= 3'b111;
            sclk_q    <= 3'b111;
            mosi_q    <= 3'b000;
            ok_q      <= 3'b000;
            armed_q   <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= 5'd0;
            rx_q      <= 16'h0000;
            tx_q      <= 8'h00;
            regs_q    <= '{default: 8'h00};
            miso_q    <= 1'b0;
            wr_strb_q <= 1'b0;
            frm_err_q <= 1'b0;
            busy_q    <= 1'b0;
            wr_addr_q <= 7'd0;
            wr_data_q <= 8'h00;
        end else begin
            ss_q      <= ss_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            ok_q      <= ok_d;
            armed_q   <= armed_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            regs_q    <= regs_d;
            miso_q    <= miso_d;
            wr_strb_q <= wr_strb_d;
            frm_err_q <= frm_err_d;
            busy_q    <= busy_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign MISO    = miso_q;
    assign wr_strb = wr_strb_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign frm_err = frm_err_q;
    assign busy    = busy_q;
endmodule
